// File: rtl/echo_frame_writer_if.sv
// ---------------------------------------------------------------------------
// echo_frame_writer_if
//   Paired echo-sample stream that feeds echo_frame_writer.
//
//   Handshake: a pair {sample_a, sample_b, sample_last} moves on a rising
//   clock edge where sample_valid && sample_ready are both high. The master
//   holds the pair and its valid until that edge. sample_ready may change
//   combinationally with the FIFO full flags. Pairs presented while ready
//   is low are not consumed.
//
//   Signals
//     sample_valid  master -> slave  pair valid
//     sample_a      master -> slave  channel A sample (DATA_W)
//     sample_b      master -> slave  channel B sample (DATA_W)
//     sample_last   master -> slave  final pair of a short frame
//     sample_ready  slave -> master  pair accepted this cycle if valid
// ---------------------------------------------------------------------------
interface echo_frame_writer_if #(
    parameter int DATA_W = 3
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_a;
    logic [DATA_W-1:0] sample_b;
    logic              sample_last;
    logic              sample_ready;

    modport master (
        output sample_valid, sample_a, sample_b, sample_last,
        input  sample_ready
    );

    modport slave (
        input  sample_valid, sample_a, sample_b, sample_last,
        output sample_ready
    );
endinterface

// File: rtl/echo_frame_writer.sv
// ---------------------------------------------------------------------------
// echo_frame_writer
//   Write-side front end for the A/B sample FIFOs of the delay-and-sum path.
//   A frame starts on 'start' in IDLE: the focal point is latched, FRAME_LEN
//   sample pairs are written into both FIFOs in lockstep, then both FIFOs
//   are read until empty and frame_done pulses for one cycle.
//
//   Optional feature (macro ECHO_ZERO_PAD_EN): a frame ended early by
//   sample_last is padded with zero pairs up to FRAME_LEN in the PAD state.
//   Without the macro the PAD state is not built and a short frame drains
//   immediately.
//
//   Ports
//     Clk, reset_n          clock, asynchronous active-low reset
//     start                 begin a frame (ignored unless IDLE)
//     focal_point_in        focal point captured on an accepted start
//     smp (slave)           paired sample stream (valid/ready)
//     fifo_{A,B}_full       FIFO full flags
//     fifo_{A,B}_empty      FIFO empty flags
//     write_en_fifo_{A,B}   FIFO write strobes (combinational)
//     write_data_fifo_{A,B} FIFO write data
//     read_en_fifo_{A,B}    FIFO read strobes (combinational, DRAIN only)
//     focal_point           focal point held for the current frame
//     busy                  FSM not IDLE
//     frame_done            one-cycle pulse after the drain completes
//     pair_count            pairs written in the current frame
//     state_dbg             current FSM state, for observation
// ---------------------------------------------------------------------------
module echo_frame_writer #(
    parameter int DATA_W    = 3,
    parameter int FRAME_LEN = 18,
    parameter int FP_W      = 4
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [FP_W-1:0]   focal_point_in,
    echo_frame_writer_if.slave smp,
    input  logic              fifo_A_full,
    input  logic              fifo_B_full,
    input  logic              fifo_A_empty,
    input  logic              fifo_B_empty,
    output logic              write_en_fifo_A,
    output logic              write_en_fifo_B,
    output logic [DATA_W-1:0] write_data_fifo_A,
    output logic [DATA_W-1:0] write_data_fifo_B,
    output logic              read_en_fifo_A,
    output logic              read_en_fifo_B,
    output logic [FP_W-1:0]   focal_point,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        pair_count,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        PAD   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] LEN = 8'(FRAME_LEN);

    state_t state;
    logic   room;       // both FIFOs can take a write this cycle
    logic   accept;     // stream handshake completes this cycle
    logic   pad_wr;     // zero pair written this cycle
    logic   final_pair; // the write this cycle completes the frame

    // Ready is combinational on both full flags so a pair is only ever
    // taken when it can go into both channels on the same edge.
    assign smp.sample_ready = (state == FILL) && room;

    always_comb begin
        room       = !fifo_A_full && !fifo_B_full;
        accept     = smp.sample_valid && (state == FILL) && room;
`ifdef ECHO_ZERO_PAD_EN
        pad_wr     = (state == PAD) && room;
`else
        pad_wr     = 1'b0;
`endif
        final_pair = (pair_count + 8'd1) == LEN;

        write_en_fifo_A   = accept || pad_wr;
        write_en_fifo_B   = accept || pad_wr;
        write_data_fifo_A = accept ? smp.sample_a : '0;
        write_data_fifo_B = accept ? smp.sample_b : '0;

        read_en_fifo_A = (state == DRAIN) && !fifo_A_empty;
        read_en_fifo_B = (state == DRAIN) && !fifo_B_empty;
    end

    assign state_dbg = state;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            focal_point <= '0;
            pair_count  <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FILL;
                        focal_point <= focal_point_in;
                        pair_count  <= '0;
                        busy        <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        pair_count <= pair_count + 8'd1;
                        // A full frame ends regardless of sample_last.
                        if (final_pair) begin
                            state <= DRAIN;
                        end else if (smp.sample_last) begin
`ifdef ECHO_ZERO_PAD_EN
                            state <= PAD;
`else
                            state <= DRAIN;
`endif
                        end
                    end
                end
`ifdef ECHO_ZERO_PAD_EN
                PAD: begin
                    if (pad_wr) begin
                        pair_count <= pair_count + 8'd1;
                        if (final_pair) begin
                            state <= DRAIN;
                        end
                    end
                end
`endif
                DRAIN: begin
                    if (fifo_A_empty && fifo_B_empty) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_echo_frame_writer
//   Bench for echo_frame_writer. The FIFOs are modelled as queues whose
//   sizes drive the empty flags; full flags are driven directly. Each frame
//   builds its expected write sequence (accepted pairs, then zero pairs when
//   padding is built) in exp_q, and every write strobe is compared against
//   it in order.
// ---------------------------------------------------------------------------
module tb_echo_frame_writer;
    localparam int DATA_W    = 3;
    localparam int FRAME_LEN = 18;
    localparam int FP_W      = 4;
`ifdef ECHO_ZERO_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic              reset_n;
    logic              start;
    logic [FP_W-1:0]   focal_point_in;
    logic              fifo_A_full, fifo_B_full;
    logic              fifo_A_empty, fifo_B_empty;
    logic              write_en_fifo_A, write_en_fifo_B;
    logic [DATA_W-1:0] write_data_fifo_A, write_data_fifo_B;
    logic              read_en_fifo_A, read_en_fifo_B;
    logic [FP_W-1:0]   focal_point;
    logic              busy, frame_done;
    logic [7:0]        pair_count;
    logic [2:0]        state_dbg;

    echo_frame_writer_if #(.DATA_W(DATA_W)) smp ();

    echo_frame_writer #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .FP_W(FP_W)
    ) dut (
        .Clk(Clk), .reset_n(reset_n), .start(start),
        .focal_point_in(focal_point_in), .smp(smp),
        .fifo_A_full(fifo_A_full), .fifo_B_full(fifo_B_full),
        .fifo_A_empty(fifo_A_empty), .fifo_B_empty(fifo_B_empty),
        .write_en_fifo_A(write_en_fifo_A), .write_en_fifo_B(write_en_fifo_B),
        .write_data_fifo_A(write_data_fifo_A), .write_data_fifo_B(write_data_fifo_B),
        .read_en_fifo_A(read_en_fifo_A), .read_en_fifo_B(read_en_fifo_B),
        .focal_point(focal_point), .busy(busy), .frame_done(frame_done),
        .pair_count(pair_count), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [2*DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]   fa_q[$];
    logic [DATA_W-1:0]   fb_q[$];
    int wr_cnt, rd_a_cnt, rd_b_cnt, done_cnt;
    bit accepted, prev_both_empty, in_fill;

    typedef struct {
        logic [FP_W-1:0] fp;
        int              last_at;  // 0: no sample_last
        int              pct;      // full-flag probability, percent
        int              exp_pc;
        int              exp_wr;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle rules, sampled 1ns after inputs settle and before the edge.
    task automatic observe();
        logic [2*DATA_W-1:0] e;
        accepted = smp.sample_valid && smp.sample_ready;
        check("we_lockstep", write_en_fifo_B, write_en_fifo_A);
        if (in_fill) check("ready_vs_full", smp.sample_ready, !fifo_A_full && !fifo_B_full);
        else         check("ready_outside_fill", smp.sample_ready, 1'b0);
        if (fifo_A_full || fifo_B_full) check("no_write_when_full", write_en_fifo_A, 1'b0);
        if (accepted) check("write_on_accept", write_en_fifo_A, 1'b1);
        check("rw_overlap", (write_en_fifo_A || write_en_fifo_B) && (read_en_fifo_A || read_en_fifo_B), 1'b0);
        if (write_en_fifo_A || write_en_fifo_B) begin
            wr_cnt++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("write_data", {write_data_fifo_A, write_data_fifo_B}, e);
            fa_q.push_back(write_data_fifo_A);
            fb_q.push_back(write_data_fifo_B);
        end
        if (fifo_A_empty) check("read_a_when_empty", read_en_fifo_A, 1'b0);
        if (fifo_B_empty) check("read_b_when_empty", read_en_fifo_B, 1'b0);
        if (read_en_fifo_A) begin rd_a_cnt++; if (fa_q.size() > 0) void'(fa_q.pop_front()); end
        if (read_en_fifo_B) begin rd_b_cnt++; if (fb_q.size() > 0) void'(fb_q.pop_front()); end
        if (frame_done) begin
            done_cnt++;
            check("done_after_both_empty", prev_both_empty, 1'b1);
        end
        prev_both_empty = fifo_A_empty && fifo_B_empty;
        check("pair_count_bound", pair_count <= 8'(FRAME_LEN), 1'b1);
    endtask

    // Called just after a falling edge with inputs set; ends at the next one.
    task automatic tick();
        fifo_A_empty = (fa_q.size() == 0);
        fifo_B_empty = (fb_q.size() == 0);
        #1;
        observe();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_frame(input logic [FP_W-1:0] fp);
        smp.sample_valid = 1'b0;
        start = 1'b1;
        focal_point_in = fp;
        tick();
        start = 1'b0;
        in_fill = 1'b1;
        check("start_pair_count", pair_count, 0);
        check("start_busy", busy, 1'b1);
        check("start_focal", focal_point, fp);
    endtask

    // Holds one pair on the stream until accepted (bounded).
    task automatic send_pair(input logic [2*DATA_W-1:0] pair, input bit last,
                             input int pct, input bit stall_a, input bit glitch);
        int n;
        smp.sample_valid = 1'b1;
        {smp.sample_a, smp.sample_b} = pair;
        smp.sample_last = last;
        n = 0;
        accepted = 1'b0;
        do begin
            if (stall_a && n < 3) begin
                fifo_A_full = 1'b1;
                fifo_B_full = 1'b0;
            end else begin
                fifo_A_full = ($urandom_range(99) < pct);
                fifo_B_full = ($urandom_range(99) < pct);
            end
            start = glitch && n == 0;
            if (glitch && n == 0) focal_point_in = 4'b0011;
            tick();
            if (stall_a && n < 3) check("stall_no_accept", accepted, 1'b0);
            n++;
        end while (!accepted && n < 60);
        start = 1'b0;
        check("accept_in_budget", accepted, 1'b1);
    endtask

    task automatic run_frame(input logic [FP_W-1:0] fp, input int last_at, input int pct,
                             input int exp_pc, input int exp_wr, input bit directed,
                             input int drop_b);
        int m, n;
        logic [DATA_W-1:0] a, b;
        logic [2*DATA_W-1:0] pairs[$];
        m = (last_at > 0 && last_at < FRAME_LEN) ? last_at : FRAME_LEN;
        wr_cnt = 0; rd_a_cnt = 0; rd_b_cnt = 0; done_cnt = 0;
        fifo_A_full = 1'b0; fifo_B_full = 1'b0;
        start_frame(fp);
        for (int i = 0; i < m; i++) begin
            a = directed ? DATA_W'(7 + i) : DATA_W'($urandom);
            b = directed ? DATA_W'(5 + i) : DATA_W'($urandom);
            pairs.push_back({a, b});
            exp_q.push_back({a, b});
        end
        if (PAD_ON) for (int i = m; i < FRAME_LEN; i++) exp_q.push_back('0);
        for (int i = 0; i < m; i++)
            send_pair(pairs[i], (i + 1) == last_at, pct, directed && i == 8, directed && i == 10);
        in_fill = 1'b0;
        check("focal_hold", focal_point, fp);
        repeat (drop_b) void'(fb_q.pop_back());
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            smp.sample_valid = 1'($urandom_range(1));
            smp.sample_last  = 1'($urandom_range(1));
            fifo_A_full = ($urandom_range(99) < pct);
            fifo_B_full = ($urandom_range(99) < pct);
            tick();
            n++;
        end
        smp.sample_valid = 1'b0;
        check("frame_done_seen", done_cnt, 1);
        check("busy_after_done", busy, 1'b0);
        tick();
        check("frame_done_once", done_cnt, 1);
        check("pair_count_final", pair_count, exp_pc);
        check("write_count", wr_cnt, exp_wr);
        check("reads_a", rd_a_cnt, exp_wr);
        check("reads_b", rd_b_cnt, exp_wr - drop_b);
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    function automatic int model_pc(input int last_at);
        if (last_at > 0 && last_at < FRAME_LEN && !PAD_ON) return last_at;
        return FRAME_LEN;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int la, pc;
        vecs[0] = '{4'hA, 0,  30, 18, 18};
        vecs[1] = '{4'h3, 5,  20, PAD_ON ? 18 : 5,  PAD_ON ? 18 : 5};
        vecs[2] = '{4'h7, 1,  0,  PAD_ON ? 18 : 1,  PAD_ON ? 18 : 1};
        vecs[3] = '{4'hF, 17, 40, PAD_ON ? 18 : 17, PAD_ON ? 18 : 17};
        vecs[4] = '{4'h0, 18, 25, 18, 18};

        reset_n = 1'b0; start = 1'b0; focal_point_in = '0;
        fifo_A_full = 1'b0; fifo_B_full = 1'b0;
        fifo_A_empty = 1'b1; fifo_B_empty = 1'b1;
        smp.sample_valid = 1'b0; smp.sample_a = '0; smp.sample_b = '0; smp.sample_last = 1'b0;
        in_fill = 1'b0; prev_both_empty = 1'b1;
        @(negedge Clk);
        #1;
        check("rst_ready", smp.sample_ready, 1'b0);
        check("rst_we", {write_en_fifo_A, write_en_fifo_B}, 2'b00);
        check("rst_re", {read_en_fifo_A, read_en_fifo_B}, 2'b00);
        check("rst_focal", focal_point, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_pair_count", pair_count, 0);
        check("rst_wdata", {write_data_fifo_A, write_data_fifo_B}, 0);
        @(negedge Clk);
        reset_n = 1'b1;
        tick();

        // Full frame with known data, A-full stall, ignored start, B short by 2.
        run_frame(4'b1001, 0, 0, 18, 18, 1'b1, 2);

        // Table-driven frames.
        for (int k = 0; k < 5; k++)
            run_frame(vecs[k].fp, vecs[k].last_at, vecs[k].pct, vecs[k].exp_pc, vecs[k].exp_wr, 1'b0, 0);

        // Reset after 7 pairs, with an 8th pair being offered.
        wr_cnt = 0; rd_a_cnt = 0; rd_b_cnt = 0; done_cnt = 0;
        start_frame(4'd5);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(6'(i * 5));
            send_pair(6'(i * 5), 1'b0, 0, 1'b0, 1'b0);
        end
        check("mid_pair_count", pair_count, 7);
        smp.sample_valid = 1'b1;
        fifo_A_full = 1'b0; fifo_B_full = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", {write_en_fifo_A, write_en_fifo_B}, 2'b00);
        check("mid_rst_re", {read_en_fifo_A, read_en_fifo_B}, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", smp.sample_ready, 1'b0);
        check("mid_rst_pair_count", pair_count, 0);
        check("mid_rst_focal", focal_point, 0);
        exp_q.delete(); fa_q.delete(); fb_q.delete();
        in_fill = 1'b0;
        smp.sample_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run_frame(4'b0110, 0, 10, 18, 18, 1'b0, 0);

        // Random frames against the frame-length model.
        for (int k = 0; k < 8; k++) begin
            la = $urandom_range(FRAME_LEN);
            pc = model_pc(la);
            run_frame(FP_W'($urandom), la, $urandom_range(50), pc, pc, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/echo_frame_writer.md
Name: echo_frame_writer

Overview:
- Write-side front end for the dual-channel sample FIFOs (A/B) feeding the LUT delay-and-sum path.
- Accepts paired 3-bit echo samples via valid/ready and writes one frame of FRAME_LEN pairs into both FIFOs in lockstep.
- Then drives both FIFO read enables until both FIFOs are empty, and pulses frame_done.
- Latches focal_point at frame start and holds it stable for the downstream LUT for the whole frame.

Parameters:
- DATA_W, 3, sample width per channel.
- FRAME_LEN, 18, sample pairs per frame (legal range 1..255).
- FP_W, 4, focal point width.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame. Ignored unless the FSM is in IDLE.
- focal_point_in  in  FP_W  focal point; sampled on an accepted start.
- sample_valid  in  1  upstream sample pair valid.
- sample_a  in  DATA_W  channel A sample.
- sample_b  in  DATA_W  channel B sample.
- sample_last  in  1  marks the final pair of a short frame; qualified by sample_valid.
- sample_ready  out  1  block can accept a pair this cycle.
- fifo_A_full  in  1  FIFO A full flag.
- fifo_B_full  in  1  FIFO B full flag.
- fifo_A_empty  in  1  FIFO A empty flag.
- fifo_B_empty  in  1  FIFO B empty flag.
- write_en_fifo_A  out  1  FIFO A write strobe.
- write_en_fifo_B  out  1  FIFO B write strobe.
- write_data_fifo_A  out  DATA_W  FIFO A write data.
- write_data_fifo_B  out  DATA_W  FIFO B write data.
- read_en_fifo_A  out  1  FIFO A read strobe.
- read_en_fifo_B  out  1  FIFO B read strobe.
- focal_point  out  FP_W  focal point latched for the current frame.
- busy  out  1  high when the FSM is not IDLE.
- frame_done  out  1  one-cycle pulse at end of drain.
- pair_count  out  8  number of pairs written in the current frame.

Behaviour:
- Reset (async assert, synchronous release): FSM=IDLE. All outputs are 0, including focal_point and pair_count.
- FSM states: IDLE, FILL, PAD, DRAIN, DONE.
- IDLE -> FILL on start.
  - Same edge: focal_point <= focal_point_in, pair_count <= 0.
- FILL:
  - sample_ready = !fifo_A_full && !fifo_B_full. It is combinational, so both full flags must be sampled in the same cycle as the handshake.
  - accept = sample_valid && sample_ready.
  - write_en_fifo_A = write_en_fifo_B = accept. These are combinational, so there are zero cycles of latency from accept to write.
  - write_data_fifo_A = sample_a and write_data_fifo_B = sample_b.
  - Channels are never written separately: if either FIFO is full, neither is written.
  - pair_count increments on each accept.
- Leaving FILL:
  - Accept of pair number FRAME_LEN -> DRAIN. sample_last is ignored on this pair.
  - Accept with sample_last=1 and pair_count+1 < FRAME_LEN -> PAD (feature on) or DRAIN (feature off).
- PAD (feature on only):
  - sample_ready=0.
  - Writes 0 to both FIFOs on each cycle where neither FIFO is full, until pair_count == FRAME_LEN, then -> DRAIN.
- DRAIN:
  - sample_ready=0 and write enables are 0.
  - read_en_fifo_A = !fifo_A_empty and read_en_fifo_B = !fifo_B_empty. Both are combinational.
  - When both empty flags are 1 in the same cycle -> DONE.
- DONE: frame_done=1 for exactly one cycle, then -> IDLE. pair_count holds its final value until the next start.
- start while not IDLE is ignored. focal_point is unchanged.
- sample_valid outside FILL: sample_ready=0, no write, and the data is dropped upstream (held by the valid/ready protocol).
- pair_count never exceeds FRAME_LEN and does not wrap.
- reset_n low mid-frame: immediate return to IDLE with all strobes low. Partial FIFO contents are not this block's concern.

Optional Feature:
- Macro: ECHO_ZERO_PAD_EN.
- Defined: a short frame (sample_last early) is zero-padded to exactly FRAME_LEN pairs via the PAD state, so the downstream LUT always sees a fixed frame length.
- Undefined: the PAD state is not built, and a short frame goes straight to DRAIN with pair_count equal to the number of accepted pairs.

Test Plan:
- Reset, then start with focal_point_in=4'b1001, then 18 valid pairs, A starting 3'b111 and B starting 3'b101, no full flags -> exactly 18 write strobes with matching data, focal_point=9, pair_count=18, then DRAIN.
- Hold fifo_A_full=1 for 3 cycles mid-frame with sample_valid=1 -> sample_ready=0 and both write enables 0 for those 3 cycles; no sample lost or duplicated.
- In DRAIN, model FIFO A holding 18 entries and FIFO B holding 16 -> read_en_fifo_B drops after 16 reads while read_en_fifo_A continues to 18; frame_done pulses once, one cycle after both empty flags are high.
- sample_last on pair 5:
  - ECHO_ZERO_PAD_EN defined -> 13 zero writes follow, pair_count=18.
  - ECHO_ZERO_PAD_EN undefined -> DRAIN immediately, pair_count=5.
- start pulsed during FILL with focal_point_in=4'b0011 -> ignored; focal_point stays 4'b1001.
- reset_n low after 7 pairs -> the same cycle, all strobes and busy are 0; after release, a new frame runs normally from pair_count=0.
